// File: rtl/consec_responder.sv
// Responder for the consecutive-handshake protocol: each rise of a yields
// B_LEN cycles of b followed, C_GAP cycles after the last b, by one c pulse.
module consec_responder #(
    parameter int B_LEN = 2,
    parameter int C_GAP = 1,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic [CNT_W-1:0] resp_count
);

    localparam int D = B_LEN + C_GAP;

    logic             a_q, a_d;
    logic             rise;
    logic [D-1:0]     pipe_q, pipe_d;
    logic             b_q, b_d;
    logic             c_q, c_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        a_d    = a;
        rise   = a & ~a_q & ~reset;
        pipe_d = '0;
        if (!reset) begin
            pipe_d = {pipe_q[D-2:0], rise};
        end
        // Outputs are registered copies of the pipeline's next state.
        b_d    = |pipe_d[B_LEN-1:0];
        c_d    = pipe_d[D-1];
        busy_d = |pipe_d;
        cnt_d  = cnt_q;
        if (reset) begin
            cnt_d = '0;
        end else if (c_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // a_q is never cleared so rise detection matches $rose sampling.
    always_ff @(posedge clock) begin
        a_q    <= a_d;
        pipe_q <= pipe_d;
        b_q    <= b_d;
        c_q    <= c_d;
        busy_q <= busy_d;
        cnt_q  <= cnt_d;
    end

    assign b          = b_q;
    assign c          = c_q;
    assign busy       = busy_q;
    assign resp_count = cnt_q;

endmodule

// File: tb/tb_consec_responder.sv
// Directed bench for consec_responder: default, B_LEN=3/C_GAP=2 and CNT_W=2
// instances run side by side against hand-computed per-sample expectations.
module tb_consec_responder;

    logic       clock = 1'b0;
    logic       rst0, a0, b0, c0, busy0;
    logic [7:0] cnt0;
    logic       rst1, a1, b1, c1, busy1;
    logic [7:0] cnt1;
    logic       rst2, a2, b2, c2, busy2;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    consec_responder dut_def (
        .clock(clock), .reset(rst0), .a(a0),
        .b(b0), .c(c0), .busy(busy0), .resp_count(cnt0)
    );

    consec_responder #(.B_LEN(3), .C_GAP(2)) dut_swp (
        .clock(clock), .reset(rst1), .a(a1),
        .b(b1), .c(c1), .busy(busy1), .resp_count(cnt1)
    );

    consec_responder #(.CNT_W(2)) dut_sat (
        .clock(clock), .reset(rst2), .a(a2),
        .b(b2), .c(c2), .busy(busy2), .resp_count(cnt2)
    );

    a_def: assert property (@(posedge clock) disable iff (rst0)
        $rose(a0) |=> b0[*2] ##1 c0)
        else begin errors++; $display("FAIL prop_def"); end
    a_swp: assert property (@(posedge clock) disable iff (rst1)
        $rose(a1) |=> b1[*3] ##2 c1)
        else begin errors++; $display("FAIL prop_swp"); end
    a_sat: assert property (@(posedge clock) disable iff (rst2)
        $rose(a2) |=> b2[*2] ##1 c2)
        else begin errors++; $display("FAIL prop_sat"); end

    // Default instance: lone, reset-mid, overlap, rise-in-reset, post-reset.
    int a0_on[$]    = '{1, 2, 6, 7, 10, 12, 17, 19};
    int r0_on[$]    = '{0, 8, 17, 18};
    int b0_on[$]    = '{2, 3, 7, 8, 11, 12, 13, 14, 20, 21};
    int c0_on[$]    = '{4, 13, 15, 22};
    int busy0_on[$] = '{2, 3, 4, 7, 8, 11, 12, 13, 14, 15, 20, 21, 22};
    // Sweep instance: lone rise at 20.
    int a1_on[$]    = '{20};
    int b1_on[$]    = '{21, 22, 23};
    int c1_on[$]    = '{25};
    int busy1_on[$] = '{21, 22, 23, 24, 25};
    // Saturation instance: five isolated requests.
    int a2_on[$]    = '{2, 7, 12, 17, 22};
    int c2_on[$]    = '{5, 10, 15, 20, 25};

    function automatic bit has(input int q[$], input int n);
        foreach (q[i]) if (q[i] == n) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int cnt0_exp(input int n);
        if (n >= 23) return 1;
        if (n >= 18) return 0;
        if (n >= 16) return 2;
        if (n >= 14) return 1;
        if (n >= 9)  return 0;
        if (n >= 5)  return 1;
        return 0;
    endfunction

    function automatic int cnt2_exp(input int n);
        if (n >= 16) return 3;
        if (n >= 11) return 2;
        if (n >= 6)  return 1;
        return 0;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        rst0 = 1'b1; a0 = 1'b0;
        rst1 = 1'b1; a1 = 1'b0;
        rst2 = 1'b1; a2 = 1'b0;
        for (int n = 0; n < 32; n++) begin
            @(negedge clock);
            if (n >= 1) begin
                check($sformatf("def.b@%0d", n), int'(b0), int'(has(b0_on, n)));
                check($sformatf("def.c@%0d", n), int'(c0), int'(has(c0_on, n)));
                check($sformatf("def.busy@%0d", n), int'(busy0),
                      int'(has(busy0_on, n)));
                check($sformatf("def.cnt@%0d", n), int'(cnt0), cnt0_exp(n));
                check($sformatf("swp.b@%0d", n), int'(b1), int'(has(b1_on, n)));
                check($sformatf("swp.c@%0d", n), int'(c1), int'(has(c1_on, n)));
                check($sformatf("swp.busy@%0d", n), int'(busy1),
                      int'(has(busy1_on, n)));
                check($sformatf("swp.cnt@%0d", n), int'(cnt1), (n >= 26) ? 1 : 0);
                check($sformatf("sat.c@%0d", n), int'(c2), int'(has(c2_on, n)));
                check($sformatf("sat.cnt@%0d", n), int'(cnt2), cnt2_exp(n));
            end
            rst0 = has(r0_on, n);
            a0   = has(a0_on, n);
            rst1 = (n == 0);
            a1   = has(a1_on, n);
            rst2 = (n == 0);
            a2   = has(a2_on, n);
        end
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/consec_responder.md
# consec_responder

Responder side of the consecutive-handshake protocol. It watches a request line `a` and, for every rising edge, drives `b` high for `B_LEN` consecutive cycles, then pulses `c` once `C_GAP` cycles after the last `b`. With defaults it is the driver that satisfies `$rose(a) |=> b[*2] ##1 c` under `disable iff (reset)`. It sits opposite the initiator that raises `a`, and is the DUT those protocol assertions are bound to.

## Interface
- `B_LEN`, default 2: number of consecutive `b` cycles per request; legal range ≥1.
- `C_GAP`, default 1: cycles from the last `b` of a request to its `c`; legal range ≥1.
- `CNT_W`, default 8: width of `resp_count`.
- `clock`  input  1  sole clock; all state updates on posedge.
- `reset`  input  1  synchronous, active-high reset.
- `a`  input  1  request line; each 0→1 transition is one request.
- `b`  output  1  data-valid strobe, high `B_LEN` cycles per request.
- `c`  output  1  completion pulse, one cycle per request.
- `busy`  output  1  at least one request in flight.
- `resp_count`  output  CNT_W  number of `c` pulses issued since reset; saturates.

## Operation
- Sample index n means the value seen at posedge n.
- Rise detection: `a_q` is a register that holds `a` from the previous sample.
  - `a_q` updates every cycle, including while `reset` is high. It is not cleared, which matches `$rose` sampling.
  - A rise at sample t means `a`=1 and `a_q`=0 at t, with `reset`=0 at t.
  - A rise that coincides with `reset`=1 is discarded.
- Trigger pipeline: a shift register of depth D = `B_LEN`+`C_GAP`.
  - A detected rise enters stage 1.
  - Each stage advances one position per cycle.
  - Stage D drops off the end.
- Outputs are registered and derived from the next-state of the pipeline:
  - `b` = OR of stages 1..`B_LEN`.
  - `c` = stage D.
  - `busy` = OR of all stages.
- Overlapping requests are independent and handled fully pipelined.
  - `b` is the union of each request's window.
  - `b` and `c` may be high together.
  - There is no queuing, dropping or back-pressure.
- `resp_count` increments on every sample where `c`=1 and `reset`=0. It holds at 2^CNT_W−1.
- Reset at sample s:
  - Pipeline, `b`, `c`, `busy` and `resp_count` are all 0 from sample s+1.
  - In-flight requests are flushed and never complete.
  - Output values already presented at sample s are unaffected.

## Timing
- For a rise at sample t, with no reset in (t, t+D]:
  - `b`=1 at t+1 .. t+`B_LEN`.
  - `c`=1 at t+`B_LEN`+`C_GAP`, for exactly one sample.
- Latency from rise to first `b`: 1 cycle. Latency from rise to `c`: D cycles.
- `busy`=1 at t+1 .. t+D for a lone request.
- Maximum request rate is one rise every 2 samples, because `a` must fall in between. The pipeline therefore holds at most ceil(D/2) live triggers. All are serviced.
- `resp_count` reflects a `c` at sample k from sample k+1.
- Reset values of all outputs are 0. The first sample after power-up with `reset` high forces them to 0.
- The protocol requires no `b`/`c` outside the windows above. A stage that is 0 must never assert an output.

## Test plan
- **Lone request (defaults):**
  - Stimulus: `reset` high at 0; `a` 0 at 0, 1 at 1–2, 0 from 3.
  - Required: `b`=1 at 2,3; `c`=1 at 4 only; `busy`=1 at 2–4; `resp_count`=1 from 5.
- **Reset mid-response:**
  - Stimulus: `a` rises at 6; `reset` high at 8.
  - Required: `b`=1 at 7,8; `b`=`c`=`busy`=0 at 9; no `c` for that request; `resp_count`=0 at 9.
- **Overlap (defaults):**
  - Stimulus: rises at 10 and 12.
  - Required: `b`=1 at 11–14; `c`=1 at 13 and 15; `b` and `c` both 1 at 13; `resp_count` +2.
- **Rise during reset and rise right after reset:**
  - Stimulus: `a` 0→1 at sample r with `reset`=1.
  - Required: ignored, all outputs 0.
  - Stimulus: `a`=0 during reset, 1 at the first non-reset sample r'.
  - Required: `b`=1 at r'+1,r'+2; `c`=1 at r'+3.
- **Parameter sweep, `B_LEN`=3, `C_GAP`=2:**
  - Stimulus: rise at 20.
  - Required: `b`=1 at 21–23; `c`=1 at 25; `c`=0 at 24; `busy`=1 at 21–25.
- **Saturation, `CNT_W`=2:**
  - Stimulus: 5 isolated requests.
  - Required: `resp_count` goes 1,2,3 and holds 3.
- **All scenarios:** bind the protocol property `$rose(a) |=> b[*B_LEN] ##C_GAP c` with `disable iff (reset)`. It must never fail.
